calc_multi: RTL
===============

# calc_multi

Parametrised multi-port calculator: PORTS independent request ports share one two-stage pipelined ALU through a round-robin arbiter. Each port uses the two-beat request protocol (command + operand 1, then operand 2) and receives a one-cycle tagged response on its own output lanes. It is the next generation of the four-port calc1 and adds configurable width and port count, bounded contention latency and optional saturating results.

## Interface
- PORTS, 4: number of request/response ports (2..8).
- WIDTH, 32: operand/result width (8..64, power of two).
- c_clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- req_cmd_in  in  PORTS*4  port p command at [p*4 +: 4].
- req_data_in  in  PORTS*WIDTH  port p data at [p*WIDTH +: WIDTH].
- out_resp  out  PORTS*2  port p response at [p*2 +: 2]: 0 none, 1 success, 2 error.
- out_data  out  PORTS*WIDTH  port p result at [p*WIDTH +: WIDTH]; meaningful only when that port's resp ≠ 0.

## Operation
- Commands: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right. All other nonzero values are invalid.
- Per-port capture FSM with states IDLE, OP2, PEND.
  - IDLE: nonzero cmd sampled → latch cmd and op1 → OP2.
  - OP2: sample op2 (cmd lane ignored) → PEND.
  - PEND: wait for grant → IDLE on grant.
  - A nonzero cmd sampled while in OP2 or PEND is dropped silently and produces no response.
- Arbiter: each cycle it grants at most one PEND port, searching round-robin from pointer rr. rr = 0 after reset; after a grant, rr = (granted + 1) mod PORTS.
- ALU stage 1 (grant cycle) computes; stage 2 registers resp/data/port-id and drives outputs.
- Arithmetic is unsigned and WIDTH bits wide.
  - Add: carry-out → error (overflow).
  - Subtract: op2 > op1 → error (underflow).
  - Shifts use only the low log2(WIDTH) bits of op2 as the shift amount. Bits shifted out are lost, not an error.
  - Invalid command → error.
- Error data: 0 (see Configuration).
- Success data: the WIDTH-bit result.

## Timing
- All outputs are registered. Reset values: out_resp = 0, out_data = 0 for every port, all FSMs IDLE, rr = 0, pipeline empty.
- Reset asserted mid-request or mid-pipeline discards everything; no response is emitted for in-flight requests.
- Uncontended latency: command sampled at edge E → op2 at E+1 → grant/compute in cycle after E+1 → result registered at E+3. out_resp is nonzero during the cycle following edge E+3 only.
- Contention: each grant lost to another port delays a response by one cycle. Worst case is E+3+(PORTS-1).
- out_resp is nonzero for exactly one cycle per accepted request. out_resp and out_data for a port return to 0 the next cycle unless another response for that port follows.
- Back-to-back use of one port: a new command is accepted in the cycle the port returns to IDLE, i.e. the cycle after its grant. Responses for a port are returned in request order.
- Simultaneous PEND on all ports: granted in order rr, rr+1, …, one per cycle, with no starvation.

## Configuration
- CALC_SATURATE_EN defined:
  - Add overflow returns resp 2 with data all-ones.
  - Subtract underflow returns resp 2 with data 0.
  - Invalid command returns resp 2 with data 0.
- CALC_SATURATE_EN undefined: every error returns resp 2 with data 0.
- Success behaviour is identical in both builds.

## Test plan
- Reset held 4 cycles, then released: all out_resp/out_data are 0; port 0 add 0x1 + 0x1FFFFFF (WIDTH=32) → resp 1, data 0x2000000, in the cycle after edge E+3.
- Port 0 add 0xFFFFFFFF + 1 → resp 2, data 0 (data 0xFFFFFFFF with CALC_SATURATE_EN). Subtract 1 − 0xF → resp 2, data 0. Command 3 → resp 2, data 0.
- Shift sweep, port 1: cmd 5, op1 = 1, op2 = k for k = 0..31 → data 1<<k. Cmd 6, op1 = 0x80000000, op2 = k → data 0x80000000>>k. op2 = 33 behaves as a shift by 1.
- All 4 ports issue add n + 1 on the same edge: responses appear on ports 0, 1, 2, 3 in consecutive cycles with latencies 3, 4, 5, 6. A repeat burst, with rr now at 0 again, gives the same order.
- Port 2 issues a second command while PEND: no extra response is produced, and the first result is unaffected.
- Reset asserted one cycle after op2 on port 3: no response ever appears. A subsequent add 2 + 2 → resp 1, data 4.
- PORTS=2, WIDTH=8 build: add 0xFF + 0x01 → resp 2. Shift-left 0x01 by 7 → 0x80. Both ports contending → latencies 3 and 4.

Source files
------------

// File: rtl/calc_multi.sv
// rtl/calc_multi.sv - multi-port calculator: per-port two-beat capture, round-robin arbiter, two-stage ALU; optional CALC_SATURATE_EN
module calc_multi #(
    parameter int PORTS = 4,
    parameter int WIDTH = 32
) (
    input  logic                     c_clk,
    input  logic                     reset,
    input  logic [PORTS*4-1:0]       req_cmd_in,
    input  logic [PORTS*WIDTH-1:0]   req_data_in,
    output logic [PORTS*2-1:0]       out_resp,
    output logic [PORTS*WIDTH-1:0]   out_data
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP2  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t           state_q [PORTS];
    state_t           state_d [PORTS];
    logic [3:0]       cmd_q   [PORTS];
    logic [WIDTH-1:0] op1_q   [PORTS];
    logic [WIDTH-1:0] op2_q   [PORTS];

    logic [PORTS-1:0] cap1;
    logic [PORTS-1:0] cap2;
    logic [PORTS-1:0] pend;
    logic [PORTS-1:0] grant_vec;

    logic             grant_valid;
    logic [PW-1:0]    grant_idx;
    logic [PW-1:0]    rr_q;

    logic [3:0]       alu_cmd;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH:0]   alu_sum;
    logic [1:0]       alu_resp;
    logic [WIDTH-1:0] alu_data;

    logic             s1_valid;
    logic [PW-1:0]    s1_port;
    logic [1:0]       s1_resp;
    logic [WIDTH-1:0] s1_data;

    // Capture FSM state register, one per port
    always_ff @(posedge c_clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (reset) begin
                state_q[i] <= S_IDLE;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Capture FSM next state: commands arriving outside IDLE are simply ignored
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE:  if (req_cmd_in[i*4 +: 4] != 4'd0) state_d[i] = S_OP2;
                S_OP2:   state_d[i] = S_PEND;
                S_PEND:  if (grant_vec[i]) state_d[i] = S_IDLE;
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // Capture FSM outputs: operand latch enables and pending request flags
    always_comb begin
        cap1 = '0;
        cap2 = '0;
        pend = '0;
        for (int i = 0; i < PORTS; i++) begin
            cap1[i] = (state_q[i] == S_IDLE) && (req_cmd_in[i*4 +: 4] != 4'd0);
            cap2[i] = (state_q[i] == S_OP2);
            pend[i] = (state_q[i] == S_PEND);
        end
    end

    // Per-port command and operand holding registers
    always_ff @(posedge c_clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (reset) begin
                cmd_q[i] <= 4'd0;
                op1_q[i] <= '0;
                op2_q[i] <= '0;
            end else begin
                if (cap1[i]) begin
                    cmd_q[i] <= req_cmd_in[i*4 +: 4];
                    op1_q[i] <= req_data_in[i*WIDTH +: WIDTH];
                end
                if (cap2[i]) begin
                    op2_q[i] <= req_data_in[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Round-robin search over pending ports starting at rr_q
    always_comb begin
        logic [PW:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        cand        = '0;
        for (int i = 0; i < PORTS; i++) begin
            cand = {1'b0, rr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(PORTS)) begin
                cand = cand - (PW+1)'(PORTS);
            end
            if (!grant_valid && pend[cand[PW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[PW-1:0];
            end
        end
        if (grant_valid) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // Pointer moves just past the port that won, so it goes last next time
    always_ff @(posedge c_clk) begin
        if (reset) begin
            rr_q <= '0;
        end else if (grant_valid) begin
            rr_q <= (grant_idx == PW'(PORTS-1)) ? '0 : grant_idx + PW'(1);
        end
    end

    // ALU stage 1: compute result for the granted port in the grant cycle
    always_comb begin
        alu_cmd  = cmd_q[grant_idx];
        alu_a    = op1_q[grant_idx];
        alu_b    = op2_q[grant_idx];
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_resp = RESP_ERR;
        alu_data = '0;
        case (alu_cmd)
            CMD_ADD: begin
                if (alu_sum[WIDTH]) begin
                    alu_resp = RESP_ERR;
`ifdef CALC_SATURATE_EN
                    alu_data = '1;
`else
                    alu_data = '0;
`endif
                end else begin
                    alu_resp = RESP_OK;
                    alu_data = alu_sum[WIDTH-1:0];
                end
            end
            CMD_SUB: begin
                if (alu_b > alu_a) begin
                    alu_resp = RESP_ERR;
                    alu_data = '0;
                end else begin
                    alu_resp = RESP_OK;
                    alu_data = alu_a - alu_b;
                end
            end
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = alu_a << alu_b[SW-1:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = alu_a >> alu_b[SW-1:0];
            end
            default: begin
                alu_resp = RESP_ERR;
                alu_data = '0;
            end
        endcase
    end

    // ALU stage 1 register: holds the computed response and its port
    always_ff @(posedge c_clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_port  <= '0;
            s1_resp  <= 2'd0;
            s1_data  <= '0;
        end else begin
            s1_valid <= grant_valid;
            s1_port  <= grant_idx;
            s1_resp  <= alu_resp;
            s1_data  <= alu_data;
        end
    end

    // Stage 2 output lanes: a response lives for exactly one cycle on its port
    always_ff @(posedge c_clk) begin
        if (reset) begin
            out_resp <= '0;
            out_data <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            if (s1_valid) begin
                out_resp[s1_port*2 +: 2]         <= s1_resp;
                out_data[s1_port*WIDTH +: WIDTH] <= s1_data;
            end
        end
    end

endmodule
